// File: rtl/rr_arb_mux2_pkg.sv
// Shared constants and types for the round-robin 2:1 stream mux.
// Optional grant statistics are enabled by defining RR_ARB_MUX2_STATS_EN.
// Encodings here are shared by the arbiter core and the top level.
package rr_arb_mux2_pkg;

  // Default word width of each input stream and of the output word
  localparam int DATA_W_DEF = 8;

  // Width of the optional per-source grant counters
  localparam int STATS_W = 16;

  // Priority state: which source wins when both request
  typedef enum logic {
    PRI0 = 1'b0,
    PRI1 = 1'b1
  } pri_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter: priority register plus combinational grant.
// Latency: grant is combinational from req and the current priority state.
// Backpressure: priority moves only when advance is asserted with a grant present.
module rr_arb2
  import rr_arb_mux2_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt
);

  pri_t pri_q;
  pri_t pri_d;

  // Priority state register, synchronous active-low reset to PRI0
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pri_q <= PRI0;
    end else begin
      pri_q <= pri_d;
    end
  end

  // Next priority: hand preference to the source that did not just win
  always_comb begin
    pri_d = pri_q;
    if (advance && gnt[0]) begin
      pri_d = PRI1;
    end else if (advance && gnt[1]) begin
      pri_d = PRI0;
    end
  end

  // Grant: preferred source first, the other only if the preferred one is idle
  always_comb begin
    gnt = 2'b00;
    case (pri_q)
      PRI0: begin
        if (req[0]) begin
          gnt = 2'b01;
        end else if (req[1]) begin
          gnt = 2'b10;
        end
      end
      PRI1: begin
        if (req[1]) begin
          gnt = 2'b10;
        end else if (req[0]) begin
          gnt = 2'b01;
        end
      end
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/rr_arb_mux2.sv
// Round-robin arbitrated 2:1 stream mux with a one-entry registered output buffer.
// Latency: 1 cycle from input handshake to out_valid; 1 word/cycle sustained.
// Backpressure: inputs are accepted only when the buffer is empty or being drained.
// Optional grant counters gnt_cnt0/gnt_cnt1 exist when RR_ARB_MUX2_STATS_EN is defined.
module rr_arb_mux2
  import rr_arb_mux2_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in0_valid,
  input  logic [DATA_W-1:0] in0_data,
  output logic              in0_ready,
  input  logic              in1_valid,
  input  logic [DATA_W-1:0] in1_data,
  output logic              in1_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_sel,
  input  logic              out_ready
`ifdef RR_ARB_MUX2_STATS_EN
  ,
  output logic [STATS_W-1:0] gnt_cnt0,
  output logic [STATS_W-1:0] gnt_cnt1
`endif
);

  logic [1:0]        gnt;
  logic              load;
  logic              xfer;
  logic [DATA_W-1:0] sel_data;

  rr_arb2 u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     ({in1_valid, in0_valid}),
    .advance (xfer),
    .gnt     (gnt)
  );

  // Load when the buffer is empty or its word leaves this cycle; a transfer needs a grant too
  always_comb begin
    load      = !out_valid || out_ready;
    xfer      = load && (gnt != 2'b00);
    // No handshake may complete while reset is being applied
    in0_ready = rst_n && load && gnt[0];
    in1_ready = rst_n && load && gnt[1];
    sel_data  = gnt[1] ? in1_data : in0_data;
  end

  // One-entry output buffer; holds while stalled, empties on an ungranted load cycle
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= 1'b0;
    end else if (load) begin
      out_valid <= xfer;
      if (xfer) begin
        out_data <= sel_data;
        out_sel  <= gnt[1];
      end
    end
  end

`ifdef RR_ARB_MUX2_STATS_EN
  // Per-source accepted-transfer counters, free-running with natural wrap
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      gnt_cnt0 <= '0;
      gnt_cnt1 <= '0;
    end else begin
      if (xfer && gnt[0]) begin
        gnt_cnt0 <= gnt_cnt0 + 1'b1;
      end
      if (xfer && gnt[1]) begin
        gnt_cnt1 <= gnt_cnt1 + 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_rr_arb_mux2.sv
// Directed self-checking bench for rr_arb_mux2.
// Inputs change 1 time unit after the rising edge; outputs are sampled there too.
// Grant-counter checks are included when RR_ARB_MUX2_STATS_EN is defined.
module tb_rr_arb_mux2;

  localparam int DATA_W = 8;

  logic              clk;
  logic              rst_n;
  logic              in0_valid;
  logic [DATA_W-1:0] in0_data;
  logic              in0_ready;
  logic              in1_valid;
  logic [DATA_W-1:0] in1_data;
  logic              in1_ready;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_sel;
  logic              out_ready;
`ifdef RR_ARB_MUX2_STATS_EN
  logic [15:0]       gnt_cnt0;
  logic [15:0]       gnt_cnt1;
`endif

  int vectors;
  int miscompares;

  rr_arb_mux2 #(.DATA_W(DATA_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in0_valid (in0_valid),
    .in0_data  (in0_data),
    .in0_ready (in0_ready),
    .in1_valid (in1_valid),
    .in1_data  (in1_data),
    .in1_ready (in1_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_ready (out_ready)
`ifdef RR_ARB_MUX2_STATS_EN
    ,
    .gnt_cnt0  (gnt_cnt0),
    .gnt_cnt1  (gnt_cnt1)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [7:0] d, input logic s);
    chk({tag, ".valid"}, {31'd0, out_valid}, {31'd0, v});
    chk({tag, ".data"},  {24'd0, out_data},  {24'd0, d});
    chk({tag, ".sel"},   {31'd0, out_sel},   {31'd0, s});
  endtask

  task automatic chk_rdy(input string tag, input logic r0, input logic r1);
    #1;
    chk({tag, ".rdy0"}, {31'd0, in0_ready}, {31'd0, r0});
    chk({tag, ".rdy1"}, {31'd0, in1_ready}, {31'd0, r1});
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n     = 1'b0;
    in0_valid = 1'b1;
    in1_valid = 1'b1;
    in0_data  = 8'hA0;
    in1_data  = 8'h5B;
    out_ready = 1'b1;

    // Reset held two cycles with both sources requesting
    tick();
    tick();
    chk_out("reset", 1'b0, 8'h00, 1'b0);

    // Release: first grant goes to source 0
    rst_n = 1'b1;
    chk_rdy("post_reset", 1'b1, 1'b0);

    // Contention: strict alternation 0,1,0,1
    tick(); chk_out("cont0", 1'b1, 8'hA0, 1'b0); chk_rdy("cont0", 1'b0, 1'b1);
    tick(); chk_out("cont1", 1'b1, 8'h5B, 1'b1); chk_rdy("cont1", 1'b1, 1'b0);
    tick(); chk_out("cont2", 1'b1, 8'hA0, 1'b0); chk_rdy("cont2", 1'b0, 1'b1);
    tick(); chk_out("cont3", 1'b1, 8'h5B, 1'b1); chk_rdy("cont3", 1'b1, 1'b0);

    // Backpressure: load 8'h11 from source 0, then stall three cycles
    in0_data = 8'h11;
    tick(); chk_out("bp_load", 1'b1, 8'h11, 1'b0);
    out_ready = 1'b0;
    chk_rdy("bp_stall", 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_out("bp_hold", 1'b1, 8'h11, 1'b0);
      chk_rdy("bp_hold", 1'b0, 1'b0);
    end
    // Priority unchanged by the stall: source 1 is next, popped and pushed on one edge
    out_ready = 1'b1;
    chk_rdy("bp_release", 1'b0, 1'b1);
    tick(); chk_out("bp_next", 1'b1, 8'h5B, 1'b1);

    // Single source: only source 1 streams 01,02,03 back to back
    in0_valid = 1'b0;
    in1_data  = 8'h01;
    chk_rdy("single", 1'b0, 1'b1);
    tick(); chk_out("single01", 1'b1, 8'h01, 1'b1);
    in1_data = 8'h02;
    tick(); chk_out("single02", 1'b1, 8'h02, 1'b1);
    in1_data = 8'h03;
    tick(); chk_out("single03", 1'b1, 8'h03, 1'b1);
    // Last grant went to 1, so priority is PRI0 and source 0 wins contention
    in0_valid = 1'b1;
    in0_data  = 8'hA0;
    in1_data  = 8'h5B;
    chk_rdy("single_after", 1'b1, 1'b0);
    tick(); chk_out("single_after", 1'b1, 8'hA0, 1'b0);

    // Idle cycle empties the buffer
    in0_valid = 1'b0;
    in1_valid = 1'b0;
    chk_rdy("idle", 1'b0, 1'b0);
    tick(); chk_out("idle", 1'b0, 8'hA0, 1'b0);

    // Reset mid-operation: 8'hCC held under stall is dropped
    in0_valid = 1'b1;
    in0_data  = 8'hCC;
    tick(); chk_out("mid_load", 1'b1, 8'hCC, 1'b0);
    in0_valid = 1'b0;
    out_ready = 1'b0;
    tick(); chk_out("mid_hold", 1'b1, 8'hCC, 1'b0);
    rst_n = 1'b0;
    tick(); chk_out("mid_reset", 1'b0, 8'h00, 1'b0);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    in0_valid = 1'b1;
    in1_valid = 1'b1;
    in0_data  = 8'hA0;
    // Priority was PRI1 before the reset; PRI0 afterwards
    chk_rdy("mid_pri", 1'b1, 1'b0);
    tick(); chk_out("mid_after", 1'b1, 8'hA0, 1'b0);
    in0_valid = 1'b0;
    in1_valid = 1'b0;
    tick(); chk_out("mid_drain", 1'b0, 8'hA0, 1'b0);

`ifdef RR_ARB_MUX2_STATS_EN
    // Grant counters: 5 grants to source 0, 3 to source 1, then wrap source 1
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("cnt0_reset", {16'd0, gnt_cnt0}, 32'd0);
    chk("cnt1_reset", {16'd0, gnt_cnt1}, 32'd0);
    in0_valid = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    in0_valid = 1'b0;
    in1_valid = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    in1_valid = 1'b0;
    tick();
    chk("cnt0_five",  {16'd0, gnt_cnt0}, 32'd5);
    chk("cnt1_three", {16'd0, gnt_cnt1}, 32'd3);
    in1_valid = 1'b1;
    for (int i = 0; i < 65532; i++) tick();
    in1_valid = 1'b0;
    tick();
    chk("cnt1_max", {16'd0, gnt_cnt1}, 32'h0000FFFF);
    in1_valid = 1'b1;
    tick();
    in1_valid = 1'b0;
    tick();
    chk("cnt1_wrap", {16'd0, gnt_cnt1}, 32'd0);
    chk("cnt0_still", {16'd0, gnt_cnt0}, 32'd5);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
